// File: rtl/pri_decoder_2_4_q.sv
// pri_decoder_2_4_q: receive side of the priority-encoder link.
// Accepts {code, dis} words over a valid/ready handshake, buffers them in a
// small synchronous FIFO and presents the head word decoded back to a one-hot
// 4-bit request vector. Outputs depend only on registered state and storage.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its word until that edge. in_ready never looks at
// out_ready, so a full FIFO does not accept a word in the cycle it is popped.
//
// Optional feature (macro PRI_DEC_DROP_DIS_EN): words with dis=1 are accepted
// but discarded instead of stored. A saturating 8-bit drop_cnt output counts them.
module pri_decoder_2_4_q #(
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    code,
    input  logic          dis,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    onehot,
    output logic          out_dis,
    output logic [CW-1:0] count
`ifdef PRI_DEC_DROP_DIS_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Occupancy state, kept in step with count; visible as a named signal.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [2:0]      mem [DEPTH];
    logic [2:0]      head;
    logic            push;
    logic            pop;
    logic            store;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef PRI_DEC_DROP_DIS_EN
    // Disabled words complete their handshake but never occupy an entry.
    assign store = push && !dis;
`else
    assign store = push;
`endif

    // Next occupancy from the store/pop pair of this cycle.
    always_comb begin
        count_nxt = count;
        case ({store, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Occupancy FSM next-state, following the next count.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (store) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (count_nxt == '0)            state_nxt = EMPTY;
                else if (count_nxt == CNT_FULL) state_nxt = FULL;
            end
            FULL: begin
                if (pop) state_nxt = ACTIVE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State, occupancy and pointers; reset discards every stored word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (store) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; code is forced to 00 for disabled words so an unknown
    // code never reaches the decoder.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= {dis, (dis ? 2'b00 : code)};
    end

    assign head = mem[rd_ptr];

    // Decode the head word; outputs are quiet whenever nothing is valid.
    always_comb begin
        onehot  = 4'b0000;
        out_dis = 1'b0;
        if (out_valid) begin
            out_dis = head[2];
            if (!head[2]) onehot = 4'b0001 << head[1:0];
        end
    end

`ifdef PRI_DEC_DROP_DIS_EN
    // Count dropped disabled words, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (push && dis && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pri_decoder_2_4_q.sv
// Directed testbench for pri_decoder_2_4_q (DEPTH=4).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge.
module tb_pri_decoder_2_4_q;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] code;
    logic       dis;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] onehot;
    logic       out_dis;
    logic [4:0] count;
`ifdef PRI_DEC_DROP_DIS_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    pri_decoder_2_4_q #(.DEPTH(4), .CW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .dis       (dis),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .onehot    (onehot),
        .out_dis   (out_dis),
        .count     (count)
`ifdef PRI_DEC_DROP_DIS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Drivers
    task automatic idle();
        in_valid  = 1'b0;
        code      = 2'b00;
        dis       = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Push the four codes 00,01,10,11 back-to-back with out_ready low.
    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            code     = 2'(i);
            dis      = 1'b0;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        step();
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_onehot",    32'(onehot),    32'd0);
        check("rst_out_dis",   32'(out_dis),   32'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Single push of code 10 into empty FIFO, held for 5 cycles
        in_valid = 1'b1; code = 2'b10; dis = 1'b0;
        step();
        in_valid = 1'b0;
        check("single_valid",  32'(out_valid), 32'd1);
        check("single_onehot", 32'(onehot),    32'b0100);
        check("single_count",  32'(count),     32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_onehot", 32'(onehot), 32'b0100);
        end
        check("hold_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain1_count",  32'(count),     32'd0);
        check("drain1_valid",  32'(out_valid), 32'd0);
        check("drain1_onehot", 32'(onehot),    32'd0);

        // Fill to DEPTH, then drain in order
        fill4();
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(onehot), 32'(4'b0001 << i));
            step();
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count),     32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Full with push and pop requested together: only the pop happens
        fill4();
        in_valid = 1'b1; code = 2'b01; out_ready = 1'b1;
        step();
        check("fullpp_count",    32'(count),    32'd3);
        check("fullpp_in_ready", 32'(in_ready), 32'd1);
        check("fullpp_head",     32'(onehot),   32'b0010);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("fullpp_push_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        while (exp_q.size() > 0) begin
            check("fullpp_order", 32'(onehot), 32'(exp_q.pop_front()));
            step();
        end
        out_ready = 1'b0;
        check("fullpp_end_count", 32'(count), 32'd0);

        // Streaming 20 words across pointer wrap
        out_ready = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                check("stream_count",  32'(count),     32'd1);
                check("stream_valid",  32'(out_valid), 32'd1);
                check("stream_onehot", 32'(onehot),    32'(exp_q.pop_front()));
            end
            if (k < 20) begin
                in_valid = 1'b1;
                code     = 2'((k * 3) % 4);
                dis      = 1'b0;
                exp_q.push_back(4'b0001 << ((k * 3) % 4));
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // Disabled word with a junk code
        in_valid = 1'b1; dis = 1'b1; code = 2'b11;
        step();
        in_valid = 1'b0; dis = 1'b0;
`ifdef PRI_DEC_DROP_DIS_EN
        check("drop_count",    32'(count),     32'd0);
        check("drop_valid",    32'(out_valid), 32'd0);
        check("drop_cnt1",     32'(drop_cnt),  32'd1);
        in_valid = 1'b1; dis = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0; dis = 1'b0;
        check("drop_in_ready", 32'(in_ready),  32'd1);
        check("drop_cnt_sat",  32'(drop_cnt),  32'd255);
        check("drop_count2",   32'(count),     32'd0);
`else
        check("dis_count",   32'(count),     32'd1);
        check("dis_valid",   32'(out_valid), 32'd1);
        check("dis_onehot",  32'(onehot),    32'd0);
        check("dis_out_dis", 32'(out_dis),   32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("dis_drain_out_dis", 32'(out_dis), 32'd0);
        check("dis_drain_count",   32'(count),   32'd0);
`endif

        // Asynchronous reset mid-stream with three words stored
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; code = 2'(i + 1); dis = 1'b0;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count",  32'(count),     32'd0);
        check("async_rst_valid",  32'(out_valid), 32'd0);
        check("async_rst_onehot", 32'(onehot),    32'd0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; code = 2'b11; dis = 1'b0;
        step();
        in_valid = 1'b0;
        check("post_rst_count",  32'(count),  32'd1);
        check("post_rst_onehot", 32'(onehot), 32'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pri_decoder_2_4_q.md
Name: pri_decoder_2_4_q

Overview:
- Receive side of the priority-encoder link: takes {code[1:0], dis} words from a 4-to-2 priority encoder and rebuilds the one-hot 4-bit request vector.
- Words pass through a small synchronous FIFO with valid/ready handshakes on both sides, so the encoder and consumer can run at different rates.
- Output comes from registered FIFO storage only; no combinational path from input to output.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- CW, 5, width of the occupancy count; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  encoder word present on code/dis.
- in_ready  output  1  FIFO can accept a word this cycle.
- code  input  2  encoded index of highest set request bit.
- dis  input  1  1 = no request bit set (code is don't-care).
- out_valid  output  1  onehot/out_dis hold a valid word.
- out_ready  input  1  consumer takes the word this cycle.
- onehot  output  4  decoded vector.
- out_dis  output  1  dis flag of the head word.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset: one clock, async active-low reset. While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, onehot=4'b0000, out_dis=0, in_ready=1 after release. Storage contents are not reset.
- Reset mid-operation discards all stored words immediately. A handshake in progress at reset assertion is lost.
- Push occurs on a rising edge with in_valid && in_ready. Store {dis, code} at wr_ptr, then increment wr_ptr modulo DEPTH.
- Pop occurs on a rising edge with out_valid && out_ready. Increment rd_ptr modulo DEPTH.
- in_ready = (count != DEPTH). There is no full-bypass: at full with out_ready=1, in_ready stays 0 that cycle.
- out_valid = (count != 0).
- Occupancy FSM, derived from count:
  - EMPTY (count=0): push -> ACTIVE.
  - ACTIVE: push only -> count+1; pop only -> count-1; push and pop together -> count unchanged. Reaching DEPTH -> FULL; reaching 0 -> EMPTY.
  - FULL: pop -> ACTIVE; push is impossible.
- Latency: a word pushed at edge N appears on onehot/out_valid after edge N. A push into EMPTY with out_ready=1 in the same cycle does not pop.
- Decode of the head word:
  - dis=1 -> onehot=0000, out_dis=1.
  - dis=0 -> onehot = 1 << code, out_dis=0: code 00->0001, 01->0010, 10->0100, 11->1000.
- When out_valid=0: onehot=0000 and out_dis=0, regardless of stale storage.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- X on code while dis=1 must not propagate: store code as 00 when dis=1.
- Output stability: onehot/out_dis hold steady while out_valid=1 and out_ready=0.

Optional Feature:
- Macro PRI_DEC_DROP_DIS_EN.
- Defined:
  - A handshaken word with dis=1 is accepted (in_ready unaffected) but not stored.
  - Output drop_cnt[7:0] is added; it increments on each dropped word and saturates at 255. Reset value is 0.
  - out_dis is therefore always 0 when out_valid=1.
- Undefined: dis=1 words are stored and decoded to 0000 as above, and no drop_cnt port exists.

Test Plan:
- Reset then single push of code=10, dis=0 into empty with out_ready=0 -> next cycle out_valid=1, onehot=0100, count=1; holds steady for 5 cycles.
- Push codes 00,01,10,11 back-to-back, DEPTH=4, out_ready=0 -> count=4, in_ready=0; then out_ready=1 for 4 cycles -> onehot 0001,0010,0100,1000 in order, count returns to 0.
- Full plus in_valid=1 and out_ready=1 in the same cycle -> only the pop occurs, count 4->3, the pending word is pushed the following cycle.
- Streaming 20 words with in_valid=out_ready=1 continuously -> after the first word, one word per cycle, correct order across pointer wrap, count stays 1.
- Push dis=1 with code=xx -> onehot=0000 and out_dis=1, no X on outputs. With PRI_DEC_DROP_DIS_EN: nothing stored, drop_cnt=1; 300 such pushes -> drop_cnt=255.
- Assert rst_n=0 mid-stream with count=3 -> count=0, out_valid=0, onehot=0000 immediately, without waiting for a clock edge.
